// File: rtl/bytewrite_sp_ram_modes_if.sv
// Access bus of the byte-writable single-port RAM: request fields from the
// master, registered read data and clear-engine busy flag from the slave.
interface bytewrite_sp_ram_modes_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  ena;
  logic [NUM_COL-1:0]    we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  busy;

  modport master (output ena, we, addr, din, input dout, busy);
  modport slave  (input ena, we, addr, din, output dout, busy);
endinterface

// File: rtl/bytewrite_sp_ram_modes.sv
// Single-port RAM with per-byte write enables and selectable read-during-write mode.
// Read latency 1 cycle, 2 with BYTEWRITE_RAM_OUT_REG_EN (extra output register).
// After reset the clear engine zeroes the array; accesses are ignored while busy=1.
module bytewrite_sp_ram_modes #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MODE       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bytewrite_sp_ram_modes_if.slave  bus
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                st;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] ram_q;

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  rd_upd;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Merged word: enabled columns from din, the rest from the stored word.
  always_comb begin
    old_word = mem[bus.addr];
    new_word = old_word;
    for (int c = 0; c < NUM_COL; c++) begin
      if (bus.we[c]) new_word[c*COL_WIDTH +: COL_WIDTH] = bus.din[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  generate
    if (MODE == 0) begin : g_write_first
      assign rd_next = new_word;
      assign rd_upd  = 1'b1;
    end else if (MODE == 1) begin : g_read_first
      assign rd_next = old_word;
      assign rd_upd  = 1'b1;
    end else if (MODE == 2) begin : g_no_change
      assign rd_next = old_word;
      assign rd_upd  = ~|bus.we;
    end else begin : g_bad_mode
      $error("bytewrite_sp_ram_modes: MODE must be 0, 1 or 2");
    end
  endgenerate

  // Clear engine and user writes share the single write port.
  assign wr_en   = busy | bus.ena;
  assign wr_addr = busy ? clr_addr : bus.addr;
  assign wr_data = busy ? '0 : new_word;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= CLEAR;
      busy     <= 1'b1;
      clr_addr <= '0;
      ram_q    <= '0;
    end else begin
      case (st)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            st   <= READY;
            busy <= 1'b0;
          end
        end
        READY: begin
          if (bus.ena && rd_upd) ram_q <= rd_next;
        end
        default: st <= CLEAR;
      endcase
    end
  end

  assign bus.busy = busy;

`ifdef BYTEWRITE_RAM_OUT_REG_EN
  logic                  ena_d;
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_d  <= 1'b0;
      dout_q <= '0;
    end else begin
      ena_d <= bus.ena & ~busy;
      if (ena_d) dout_q <= ram_q;
    end
  end

  assign bus.dout = dout_q;
`else
  assign bus.dout = ram_q;
`endif

endmodule
